// File: rtl/multicycle_ctrl_if.sv
// Handshake and control bundle between the LEGv8 multi-cycle control FSM
// and the instruction register / shared datapath.
interface multicycle_ctrl_if;
    logic [10:0] Opcode;
    logic        Zero;
    logic        IMemReady;
    logic        DMemReady;
    logic [1:0]  SignExtCtrl;
    logic [3:0]  ALUOp;
    logic        ALUSrc;
    logic        Reg2Loc;
    logic        IRWrite;
    logic        PCWrite;
    logic        PCSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    logic        MemToReg;
    logic        Fault;
    logic [2:0]  State;

    // datapath / memory side
    modport master (
        output Opcode, Zero, IMemReady, DMemReady,
        input  SignExtCtrl, ALUOp, ALUSrc, Reg2Loc, IRWrite, PCWrite, PCSrc,
               MemRead, MemWrite, RegWrite, MemToReg, Fault, State
    );

    // control FSM side
    modport slave (
        input  Opcode, Zero, IMemReady, DMemReady,
        output SignExtCtrl, ALUOp, ALUSrc, Reg2Loc, IRWrite, PCWrite, PCSrc,
               MemRead, MemWrite, RegWrite, MemToReg, Fault, State
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle LEGv8 control: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// The opcode is captured while in DECODE so the datapath controls stay
// stable through EXEC, MEM and WB even if the IR input moves.
module multicycle_ctrl (
    input  logic              CLK,
    input  logic              Reset,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        FAULT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {K_ILL, K_R, K_I, K_LD, K_ST, K_CBZ, K_B} kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [1:0] sext;
        logic [3:0] aluop;
        logic       alusrc;
        logic       reg2loc;
    } dec_t;

    // Opcode -> instruction class plus the datapath controls it implies.
    function automatic dec_t decode(input logic [10:0] op);
        dec_t d;
        d.kind    = K_ILL;
        d.sext    = 2'b00;
        d.aluop   = 4'b0010;
        d.alusrc  = 1'b0;
        d.reg2loc = 1'b0;
        casez (op)
            11'b11111000010: begin d.kind = K_LD;  d.sext = 2'b01; d.alusrc = 1'b1; end
            11'b11111000000: begin d.kind = K_ST;  d.sext = 2'b01; d.alusrc = 1'b1; d.reg2loc = 1'b1; end
            11'b10001011000: begin d.kind = K_R;   d.aluop = 4'b0010; end
            11'b11001011000: begin d.kind = K_R;   d.aluop = 4'b0110; end
            11'b10001010000: begin d.kind = K_R;   d.aluop = 4'b0000; end
            11'b10101010000: begin d.kind = K_R;   d.aluop = 4'b0001; end
            11'b1001000100?: begin d.kind = K_I;   d.aluop = 4'b0010; d.alusrc = 1'b1; end
            11'b1101000100?: begin d.kind = K_I;   d.aluop = 4'b0110; d.alusrc = 1'b1; end
            11'b10110100???: begin d.kind = K_CBZ; d.sext = 2'b11; d.aluop = 4'b0111; d.reg2loc = 1'b1; end
            11'b000101?????: begin d.kind = K_B;   d.sext = 2'b10; end
            default:         d.kind = K_ILL;
        endcase
        return d;
    endfunction

    state_t      state, state_nx;
    logic [10:0] op_q;
    dec_t        cur, held;

    // In DECODE the live IR drives the controls; afterwards the captured copy.
    assign cur  = decode((state == DECODE) ? bus.Opcode : op_q);
    // FETCH keeps showing the previous instruction's extender mode.
    assign held = decode(op_q);

    assign bus.State = state;

    // State register.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) state <= FETCH;
        else       state <= state_nx;
    end

    // Capture the opcode as the FSM leaves DECODE.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset)                op_q <= '0;
        else if (state == DECODE) op_q <= bus.Opcode;
    end

    // Next state and control outputs.
    always_comb begin
        state_nx        = state;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        bus.Fault       = 1'b0;
        bus.SignExtCtrl = held.sext;
        bus.ALUOp       = 4'b0010;
        bus.ALUSrc      = 1'b0;
        bus.Reg2Loc     = 1'b0;

        if (state == DECODE || state == EXEC || state == MEM || state == WB) begin
            bus.SignExtCtrl = cur.sext;
            bus.ALUOp       = cur.aluop;
            bus.ALUSrc      = cur.alusrc;
            bus.Reg2Loc     = cur.reg2loc;
        end

        case (state)
            FETCH: begin
                bus.IRWrite = bus.IMemReady;
                if (bus.IMemReady) state_nx = DECODE;
            end
            DECODE: state_nx = (cur.kind == K_ILL) ? FAULT : EXEC;
            EXEC: begin
                case (cur.kind)
                    K_R, K_I:   state_nx = WB;
                    K_LD, K_ST: state_nx = MEM;
                    K_CBZ: begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = bus.Zero;
                        state_nx    = FETCH;
                    end
                    K_B: begin
                        bus.PCWrite = 1'b1;
                        bus.PCSrc   = 1'b1;
                        state_nx    = FETCH;
                    end
                    default: state_nx = FAULT;
                endcase
            end
            MEM: begin
                if (cur.kind == K_LD) begin
                    bus.MemRead = 1'b1;
                    if (bus.DMemReady) state_nx = WB;
                end else if (cur.kind == K_ST) begin
                    bus.MemWrite = 1'b1;
                    if (bus.DMemReady) begin
                        bus.PCWrite = 1'b1;
                        state_nx    = FETCH;
                    end
                end else begin
                    state_nx = FAULT;
                end
            end
            WB: begin
                bus.RegWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                bus.MemToReg = (cur.kind == K_LD);
                state_nx     = FETCH;
            end
            FAULT:   bus.Fault = 1'b1;
            default: state_nx = FAULT;
        endcase
    end

endmodule
